dt_pack: RTL and testbench

DT_PACK -- requirements
Module: dt_pack

---
 rtl/dt_pack.sv | 189 ++++++++++++++++++
 tb/tb_dt_pack.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dt_pack.sv
// dt_pack -- threshold-and-pack engine.
//
// Scans a 128x128 8-bit distance map (16384x8 RAM, one-cycle read latency)
// and packs each pixel's (value > thr) flag into a 1024x16 binary-image RAM.
// Pixel 16n+k lands in word n, bit (15-k). Each word takes 18 cycles:
// 16 READ, 1 DRAIN (last datum returns), 1 WRITE.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   start     in   one-cycle pulse, accepted only in IDLE or FIN
//   thr       in   [7:0]  threshold, latched when start is accepted
//   res_rd    out  distance-map read strobe
//   res_addr  out  [13:0] distance-map address {y, x}
//   res_di    in   [7:0]  read data, valid the cycle after res_rd
//   sti_wr    out  binary-image write strobe
//   sti_addr  out  [9:0]  binary-image word address
//   sti_do    out  [15:0] packed word (MSB = leftmost pixel)
//   busy      out  pass in progress
//   done      out  pass complete, held until the next accepted start
//   pix_cnt   out  [14:0] number of 1-bits written this pass
//   max_dist  out  [7:0]  largest distance read this pass
//
// Build option
//   DT_PACK_MAXD_EN  when defined, max_dist tracks the running maximum of
//                    res_di; otherwise max_dist is tied to zero.

module dt_pack (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  thr,
  output logic        res_rd,
  output logic [13:0] res_addr,
  input  logic [7:0]  res_di,
  output logic        sti_wr,
  output logic [9:0]  sti_addr,
  output logic [15:0] sti_do,
  output logic        busy,
  output logic        done,
  output logic [14:0] pix_cnt,
  output logic [7:0]  max_dist
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_WRITE,
    S_FIN
  } state_t;

  state_t      state_q;
  logic [7:0]  thr_q;
  logic [3:0]  k_q;
  logic        res_rd_q;
  logic [13:0] res_addr_q;
  logic        sti_wr_q;
  logic [9:0]  sti_addr_q;
  logic [15:0] sti_do_q;
  logic        busy_q;
  logic        done_q;
  logic [14:0] pix_cnt_q;

  // Datapath: cap_q marks cycles in which res_di carries valid read data.
  logic        cap_q;
  logic [15:0] pack_q;
  logic [15:0] pack_d;
  logic        start_acc;

  function automatic logic [4:0] popcnt16(input logic [15:0] w);
    logic [4:0] c;
    c = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      c = c + {4'd0, w[i]};
    end
    return c;
  endfunction

  assign start_acc = start && ((state_q == S_IDLE) || (state_q == S_FIN));
  assign pack_d    = {pack_q[14:0], (res_di > thr_q)};

  // Control FSM; all memory-facing and status outputs are registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      thr_q      <= '0;
      k_q        <= '0;
      res_rd_q   <= 1'b0;
      res_addr_q <= '0;
      sti_wr_q   <= 1'b0;
      sti_addr_q <= '0;
      sti_do_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pix_cnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_FIN: begin
          if (start) begin
            state_q    <= S_READ;
            thr_q      <= thr;
            k_q        <= '0;
            sti_addr_q <= '0;
            pix_cnt_q  <= '0;
            res_rd_q   <= 1'b1;
            res_addr_q <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
          end
        end
        S_READ: begin
          if (k_q == 4'd15) begin
            state_q  <= S_DRAIN;
            res_rd_q <= 1'b0;
          end else begin
            k_q        <= k_q + 4'd1;
            res_addr_q <= {sti_addr_q, k_q + 4'd1};
          end
        end
        S_DRAIN: begin
          // The 16th datum arrives this cycle, so the word is taken from the
          // shift path rather than from pack_q.
          state_q  <= S_WRITE;
          sti_wr_q <= 1'b1;
          sti_do_q <= pack_d;
        end
        S_WRITE: begin
          sti_wr_q  <= 1'b0;
          pix_cnt_q <= pix_cnt_q + {10'd0, popcnt16(sti_do_q)};
          if (sti_addr_q != 10'h3FF) begin
            state_q    <= S_READ;
            sti_addr_q <= sti_addr_q + 10'd1;
            k_q        <= '0;
            res_rd_q   <= 1'b1;
            res_addr_q <= {sti_addr_q + 10'd1, 4'd0};
          end else begin
            state_q <= S_FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_q  <= 1'b0;
      pack_q <= '0;
    end else begin
      cap_q <= res_rd_q;
      if (start_acc) begin
        pack_q <= '0;
      end else if (cap_q) begin
        pack_q <= pack_d;
      end
    end
  end

`ifdef DT_PACK_MAXD_EN
  logic [7:0] max_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      max_q <= '0;
    end else if (start_acc) begin
      max_q <= '0;
    end else if (cap_q && (res_di > max_q)) begin
      max_q <= res_di;
    end
  end

  assign max_dist = max_q;
`else
  assign max_dist = '0;
`endif

  assign res_rd   = res_rd_q;
  assign res_addr = res_addr_q;
  assign sti_wr   = sti_wr_q;
  assign sti_addr = sti_addr_q;
  assign sti_do   = sti_do_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pix_cnt  = pix_cnt_q;

endmodule

// File: tb/tb_dt_pack.sv
// Bench for dt_pack: RAM models around the DUT, a whole-image reference
// computed directly from the map and threshold, and directed passes with
// randomized map contents and thresholds.

module tb_dt_pack;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  thr;
  logic        res_rd;
  logic [13:0] res_addr;
  logic [7:0]  res_di;
  logic        sti_wr;
  logic [9:0]  sti_addr;
  logic [15:0] sti_do;
  logic        busy;
  logic        done;
  logic [14:0] pix_cnt;
  logic [7:0]  max_dist;

  dt_pack dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .thr      (thr),
    .res_rd   (res_rd),
    .res_addr (res_addr),
    .res_di   (res_di),
    .sti_wr   (sti_wr),
    .sti_addr (sti_addr),
    .sti_do   (sti_do),
    .busy     (busy),
    .done     (done),
    .pix_cnt  (pix_cnt),
    .max_dist (max_dist)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  mem [16384];
  logic [15:0] got [1024];

  int          cyc = 0;
  int          s0 = 0;
  int          overlap = 0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          order_err = 0;
  logic [9:0]  exp_waddr = '0;

  always @(posedge clk) cyc++;

  // Distance-map RAM: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (res_rd) res_di <= mem[res_addr];
  end

  // Binary-image RAM capture plus per-cycle protocol observation.
  always @(negedge clk) begin
    if (res_rd && sti_wr) overlap++;
    if (res_rd) rd_cnt++;
    if (sti_wr) begin
      if (sti_addr != exp_waddr) order_err++;
      got[sti_addr] = sti_do;
      wr_cnt++;
      exp_waddr = exp_waddr + 10'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    overlap   = 0;
    wr_cnt    = 0;
    rd_cnt    = 0;
    order_err = 0;
    exp_waddr = '0;
    for (int n = 0; n < 1024; n++) got[n] = 16'hDEAD;
  endtask

  task automatic pulse_start(input logic [7:0] t);
    @(negedge clk);
    start = 1'b1;
    thr   = t;
    @(negedge clk);
    start = 1'b0;
    thr   = 8'($urandom);
    s0    = cyc;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    chk({tag, "_latency"}, cyc - s0, 32'd18432);
  endtask

  // Reference: every pixel judged independently against the threshold.
  task automatic check_pass(input string tag, input logic [7:0] t);
    logic [15:0] w;
    int          ones;
    logic [7:0]  mx;
    ones = 0;
    mx   = 8'd0;
    for (int n = 0; n < 1024; n++) begin
      w = 16'h0000;
      for (int k = 0; k < 16; k++) begin
        if (mem[16*n + k] > t) begin
          w[15-k] = 1'b1;
          ones++;
        end
        if (mem[16*n + k] > mx) mx = mem[16*n + k];
      end
      chk($sformatf("%s_word%0d", tag, n), {16'd0, got[n]}, {16'd0, w});
    end
`ifndef DT_PACK_MAXD_EN
    mx = 8'd0;
`endif
    chk({tag, "_pix_cnt"},  {17'd0, pix_cnt}, ones);
    chk({tag, "_max_dist"}, {24'd0, max_dist}, {24'd0, mx});
    chk({tag, "_writes"},   wr_cnt, 32'd1024);
    chk({tag, "_reads"},    rd_cnt, 32'd16384);
    chk({tag, "_order"},    order_err, 32'd0);
    chk({tag, "_overlap"},  overlap, 32'd0);
    chk({tag, "_busy_fin"}, {31'd0, busy}, 32'd0);
    chk({tag, "_sti_addr_fin"}, {22'd0, sti_addr}, 32'd1023);
    chk({tag, "_sti_do_hold"}, {16'd0, sti_do}, {16'd0, got[1023]});
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_res_rd"},   {31'd0, res_rd}, 32'd0);
    chk({tag, "_res_addr"}, {18'd0, res_addr}, 32'd0);
    chk({tag, "_sti_wr"},   {31'd0, sti_wr}, 32'd0);
    chk({tag, "_sti_addr"}, {22'd0, sti_addr}, 32'd0);
    chk({tag, "_sti_do"},   {16'd0, sti_do}, 32'd0);
    chk({tag, "_busy"},     {31'd0, busy}, 32'd0);
    chk({tag, "_done"},     {31'd0, done}, 32'd0);
    chk({tag, "_pix_cnt"},  {17'd0, pix_cnt}, 32'd0);
    chk({tag, "_max_dist"}, {24'd0, max_dist}, 32'd0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16384; i++) begin
      mem[i] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
    end
  endtask

  initial begin
    int n;
    start  = 1'b0;
    thr    = 8'd0;
    res_di = 8'd0;
    reset  = 1'b0;
    clear_mon();

    // Reset state
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_no_rd", rd_cnt, 32'd0);

    // Pass A: 5 at pixels 15 and 16383, 3 elsewhere, thr=4;
    // a start pulse at word 10 must be ignored.
    for (int i = 0; i < 16384; i++) mem[i] = 8'd3;
    mem[15]    = 8'd5;
    mem[16383] = 8'd5;
    clear_mon();
    pulse_start(8'd4);
    chk("A_busy", {31'd0, busy}, 32'd1);
    chk("A_done", {31'd0, done}, 32'd0);
    n = 0;
    while (sti_addr != 10'd10 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("A_reach_word10", {22'd0, sti_addr}, 32'd10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("A_ignore_busy", {31'd0, busy}, 32'd1);
    chk("A_ignore_addr", {22'd0, sti_addr}, 32'd10);
    wait_done("A");
    chk("A_word0", {16'd0, got[0]}, 32'h0001);
    chk("A_word1023", {16'd0, got[1023]}, 32'h0001);
    check_pass("A", 8'd4);

    // Pass B: random map and threshold, started from FIN.
    fill_random();
    clear_mon();
    begin
      logic [7:0] tb_thr;
      tb_thr = 8'($urandom);
      pulse_start(tb_thr);
      chk("B_done_drop", {31'd0, done}, 32'd0);
      chk("B_pix_clear", {17'd0, pix_cnt}, 32'd0);
      chk("B_max_clear", {24'd0, max_dist}, 32'd0);
      chk("B_busy", {31'd0, busy}, 32'd1);
      wait_done("B");
      check_pass("B", tb_thr);
    end

    // Pass C: reset asserted 500 cycles into a pass.
    fill_random();
    clear_mon();
    pulse_start(8'd0);
    repeat (499) @(negedge clk);
    chk("C_busy_before_rst", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check_all_zero("C_rst");
    @(negedge clk);
    check_all_zero("C_rst_hold");
    reset = 1'b1;
    clear_mon();
    repeat (20) @(negedge clk);
    chk("C_quiet_rd", rd_cnt, 32'd0);
    chk("C_quiet_wr", wr_cnt, 32'd0);

    // Pass D: thr=0 reproduces the binary image of the same map.
    clear_mon();
    pulse_start(8'd0);
    wait_done("D");
    check_pass("D", 8'd0);

    // Pass E: thr=255 gives all-zero words.
    clear_mon();
    pulse_start(8'd255);
    wait_done("E");
    check_pass("E", 8'd255);
    chk("E_pix_zero", {17'd0, pix_cnt}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
